// File: rtl/dest_arbiter.sv
// Two-destination read arbiter: drains FIFOs D0/D1 in bursts of up to BURST
// words, merges the returned words onto one registered output stream and
// keeps per-source saturating word counts plus a sticky protocol-error flag.
module dest_arbiter #(
    parameter int unsigned BURST = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             D0_EMPTY,
    input  logic             D1_EMPTY,
    input  logic             D0_VALID,
    input  logic             D1_VALID,
    input  logic [5:0]       DATA_OUT_D0,
    input  logic [5:0]       DATA_OUT_D1,
    input  logic             PAUSE_IN,
    output logic             POP_D0,
    output logic             POP_D1,
    output logic [5:0]       DATA_OUT,
    output logic             VALID_OUT,
    output logic [CNT_W-1:0] CNT_D0,
    output logic [CNT_W-1:0] CNT_D1,
    output logic             ERR_OUT
);

    localparam int unsigned BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE_D0 = 2'd1,
        SERVE_D1 = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [BURST_W-1:0] burst, burst_nxt, burst_inc;
    logic               last_d1, last_d1_nxt;   // last_served: 0 = D0, 1 = D1
    logic               pop_d0_q, pop_d1_q;
    logic               pop_any, serving_d1, own_empty, other_empty, burst_done;

    // Pops are only issued from a serving state, never while paused or in reset
    assign POP_D0  = (state == SERVE_D0) & ~D0_EMPTY & ~PAUSE_IN & ~RESET;
    assign POP_D1  = (state == SERVE_D1) & ~D1_EMPTY & ~PAUSE_IN & ~RESET;
    assign pop_any = POP_D0 | POP_D1;

    // Arbitration state register
    always_ff @(posedge clk) begin
        if (RESET) begin
            state   <= IDLE;
            burst   <= '0;
            last_d1 <= 1'b1;
        end else begin
            state   <= state_nxt;
            burst   <= burst_nxt;
            last_d1 <= last_d1_nxt;
        end
    end

    // Next-state: pick a source from IDLE, rotate on burst end or source drain
    always_comb begin
        state_nxt   = state;
        burst_nxt   = burst;
        last_d1_nxt = last_d1;
        burst_inc   = burst;
        burst_done  = 1'b0;
        serving_d1  = (state == SERVE_D1);
        own_empty   = serving_d1 ? D1_EMPTY : D0_EMPTY;
        other_empty = serving_d1 ? D0_EMPTY : D1_EMPTY;
        case (state)
            IDLE: begin
                if (!D0_EMPTY && (D1_EMPTY || last_d1)) begin
                    state_nxt = SERVE_D0;
                end else if (!D1_EMPTY) begin
                    state_nxt = SERVE_D1;
                end
            end
            SERVE_D0, SERVE_D1: begin
                if (pop_any) begin
                    burst_inc   = (burst >= BURST_MAX) ? BURST_MAX : burst + BURST_W'(1);
                    last_d1_nxt = serving_d1;
                end
                burst_done = pop_any && (burst_inc == BURST_MAX);
                burst_nxt  = burst_inc;
                if ((burst_done || own_empty) && !other_empty) begin
                    state_nxt = serving_d1 ? SERVE_D0 : SERVE_D1;
                    burst_nxt = '0;
                end else if (own_empty) begin
                    state_nxt = IDLE;
                    burst_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                burst_nxt = '0;
            end
        endcase
    end

    // Output merge, saturating counters and sticky protocol-error detection
    always_ff @(posedge clk) begin
        if (RESET) begin
            DATA_OUT  <= '0;
            VALID_OUT <= 1'b0;
            CNT_D0    <= '0;
            CNT_D1    <= '0;
            ERR_OUT   <= 1'b0;
            pop_d0_q  <= 1'b0;
            pop_d1_q  <= 1'b0;
        end else begin
            VALID_OUT <= D0_VALID | D1_VALID;
            if (D0_VALID) begin
                DATA_OUT <= DATA_OUT_D0;
                if (CNT_D0 != CNT_MAX) CNT_D0 <= CNT_D0 + CNT_W'(1);
            end else if (D1_VALID) begin
                DATA_OUT <= DATA_OUT_D1;
                if (CNT_D1 != CNT_MAX) CNT_D1 <= CNT_D1 + CNT_W'(1);
            end
            if ((D0_VALID && !pop_d0_q) || (D1_VALID && !pop_d1_q) || (D0_VALID && D1_VALID)) begin
                ERR_OUT <= 1'b1;
            end
            pop_d0_q <= POP_D0;
            pop_d1_q <= POP_D1;
        end
    end

endmodule
